// File: rtl/bram_log_pkg.sv
// Shared state encoding and sizing helper for the BRAM capture/readout sequencer.
package bram_log_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int clogb2(input int depth);
    int r;
    int d;
    r = 0;
    d = depth;
    while (d > 0) begin
      r = r + 1;
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_log_ctrl_rdpipe.sv
// Read-valid delay line: one bit per cycle of request-to-data latency, flushable.
module bram_log_rdpipe #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic req,
  output logic vld
);

  logic [STAGES-1:0] vld_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (STAGES == 1) begin
      vld_p[0] <= req;
    end else begin
      vld_p <= {vld_p[STAGES-2:0], req};
    end
  end

  assign vld = vld_p[STAGES-1];

endmodule

// File: rtl/bram_log_ctrl.sv
// Capture/readout sequencer owning the single port of a no-change BRAM.
// Optional macro BRAM_LOG_CIRCULAR_EN: wrap-around capture with i_stop / o_wr_ptr.
module bram_log_ctrl
  import bram_log_pkg::*;
#(
  parameter int RAM_WIDTH  = 18,
  parameter int RAM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2,
  localparam int ADDR_W    = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [RAM_WIDTH-1:0] i_data,
  input  logic                 i_rd_req,
  input  logic [ADDR_W-1:0]    i_rd_addr,
`ifdef BRAM_LOG_CIRCULAR_EN
  input  logic                 i_stop,
  output logic [ADDR_W-1:0]    o_wr_ptr,
`endif
  output logic [RAM_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_busy,
  output logic [ADDR_W:0]      o_count,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic                 o_ram_regce,
  output logic                 o_ram_rst,
  output logic [ADDR_W-1:0]    o_ram_addr,
  output logic [RAM_WIDTH-1:0] o_ram_din,
  input  logic [RAM_WIDTH-1:0] i_ram_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(RAM_DEPTH);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_nxt;
  logic [ADDR_W:0]     count_nxt;
  logic                wr_req, rd_req;

  // Clear beats start; start beats everything else, including a pending read.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    count_nxt   = o_count;
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    if (i_clear) begin
      state_nxt   = IDLE;
      wr_addr_nxt = '0;
      count_nxt   = '0;
    end else if (i_start) begin
      state_nxt   = CAPTURE;
      wr_addr_nxt = '0;
      count_nxt   = '0;
    end else begin
      case (state)
        CAPTURE: begin
          if (i_valid) begin
            wr_req      = 1'b1;
            wr_addr_nxt = (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
`ifdef BRAM_LOG_CIRCULAR_EN
            if (o_count != FULL_CNT) count_nxt = o_count + 1'b1;
`else
            count_nxt = o_count + 1'b1;
            if (wr_addr == LAST_ADDR) state_nxt = DONE;
`endif
          end
`ifdef BRAM_LOG_CIRCULAR_EN
          if (i_stop) state_nxt = DONE;
`endif
        end
        DONE:    rd_req = i_rd_req;
        default: ;
      endcase
    end
  end

  // RAM port is fully registered: requests land on the port one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      o_count    <= '0;
      o_ram_en   <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_rst  <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
    end else begin
      state     <= state_nxt;
      wr_addr   <= wr_addr_nxt;
      o_count   <= count_nxt;
      o_ram_en  <= wr_req | rd_req;
      o_ram_we  <= wr_req;
      o_ram_rst <= i_clear;
      if (wr_req) begin
        o_ram_addr <= wr_addr;
        o_ram_din  <= i_data;
      end else if (rd_req) begin
        o_ram_addr <= i_rd_addr;
      end
    end
  end

  // One stage for the port register plus the RAM's own read latency.
  bram_log_rdpipe #(
    .STAGES(RD_LATENCY + 1)
  ) u_rdpipe (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(i_clear),
    .req  (rd_req),
    .vld  (o_rd_valid)
  );

  assign o_rd_data   = o_rd_valid ? i_ram_dout : '0;
  assign o_ram_regce = 1'b1;
  assign o_full      = (state == DONE);
  assign o_busy      = (state == CAPTURE);
`ifdef BRAM_LOG_CIRCULAR_EN
  assign o_wr_ptr    = wr_addr;
`endif

endmodule

// File: doc/bram_log_ctrl.md
Name: bram_log_ctrl

Overview:
Capture/readout sequencer for the single-port no-change BRAM (xilinx_single_port_ram_no_change).
- Fills the RAM with a burst of RAM_DEPTH streamed samples (e.g. PRBS/filter output), then serves host random-access reads.
- Owns all RAM port signals and arbitrates the single port between the capture writer and the host reader (capture has priority).
- Hides the RAM read latency behind a valid strobe.

Parameters:
RAM_WIDTH, 18, sample/data width; must match the RAM instance.
RAM_DEPTH, 1024, number of words; ADDR_W = clogb2(RAM_DEPTH-1).
RD_LATENCY, 2, RAM read latency in cycles: 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY.

Ports:
clk  in  1  system clock; also drives the RAM clka.
rst_n  in  1  asynchronous active-low reset.
i_start  in  1  pulse: begin a new capture at address 0.
i_clear  in  1  pulse: abort; return to IDLE.
i_valid  in  1  input sample valid.
i_data  in  RAM_WIDTH  input sample.
i_rd_req  in  1  host read request; one word per cycle.
i_rd_addr  in  ADDR_W  host read address.
o_rd_data  out  RAM_WIDTH  read data.
o_rd_valid  out  1  o_rd_data valid, one-cycle strobe.
o_full  out  1  capture complete (DONE state).
o_busy  out  1  capture in progress (CAPTURE state).
o_count  out  ADDR_W+1  words written in the current capture.
o_ram_en, o_ram_we, o_ram_regce, o_ram_rst  out  1  RAM controls.
o_ram_addr  out  ADDR_W  RAM address.
o_ram_din  out  RAM_WIDTH  RAM write data.
i_ram_dout  in  RAM_WIDTH  RAM douta.

Behaviour:
Reset:
- State IDLE; all outputs 0, except o_ram_regce = 1 (constant).
- Read valid pipeline cleared.

Output timing:
- All RAM-side outputs are registered: a request made in cycle N appears on the RAM port in cycle N+1.

States:
- IDLE -> CAPTURE on i_start.
  - wr_addr = 0, o_count = 0.
  - i_rd_req ignored.
- CAPTURE: on each cycle with i_valid = 1:
  - next cycle: o_ram_en = 1, o_ram_we = 1, o_ram_addr = wr_addr, o_ram_din = i_data;
  - wr_addr and o_count increment.
  - i_valid = 0 cycles: o_ram_en = 0, o_ram_we = 0.
  - i_rd_req ignored (no read issued, no o_rd_valid).
  - When o_count reaches RAM_DEPTH (the write of address RAM_DEPTH-1) -> DONE, o_full = 1.
  - i_start in CAPTURE restarts the capture at address 0 with o_count = 0.
- DONE: on i_rd_req:
  - next cycle: o_ram_en = 1, o_ram_we = 0, o_ram_addr = i_rd_addr.
  - o_rd_valid = 1 with o_rd_data = i_ram_dout exactly 1 + RD_LATENCY cycles after the request (3 by default).
  - Back-to-back requests give back-to-back valid strobes.
  - i_valid ignored.
  - i_start -> CAPTURE; reads already in flight still complete with correct data.
- i_clear in any state (priority over i_start):
  - -> IDLE; o_count = 0, o_full = 0;
  - read valid pipeline flushed, so no o_rd_valid after the clear;
  - o_ram_rst = 1 for exactly one cycle to zero the RAM output register.

Address arithmetic:
- wr_addr is ADDR_W wide.
- o_count is ADDR_W+1 wide, so RAM_DEPTH is representable.

Optional Feature:
Macro: BRAM_LOG_CIRCULAR_EN.
- Defined:
  - CAPTURE never moves to DONE. wr_addr wraps from RAM_DEPTH-1 to 0.
  - o_count saturates at RAM_DEPTH.
  - Extra input i_stop moves CAPTURE -> DONE.
  - Extra output o_wr_ptr [ADDR_W] holds the next write address, i.e. the oldest sample once o_count = RAM_DEPTH.
- Undefined: one-shot fill as described above; i_stop and o_wr_ptr do not exist.

Decomposition:
- Package bram_log_pkg:
  - state encoding constants: IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2;
  - clogb2 function.
- One sub-module, bram_log_rdpipe: a RD_LATENCY+1 deep valid shift register with synchronous flush, producing o_rd_valid.

Test Plan:
- Reset and idle: hold rst_n = 0, then release -> all outputs 0, o_ram_regce = 1; i_rd_req in IDLE gives no o_rd_valid.
- Capture with gaps: i_start, then 1024 samples data = addr with i_valid toggling 1/0 -> exactly 1024 RAM writes at addresses 0..1023; o_full rises the cycle after the write to 1023; o_count = 1024; extra i_valid writes nothing.
- Read latency: in DONE, read 0, 1, 1023 back-to-back -> o_rd_valid in cycles +3, +4, +5 with data 0, 1, 1023. With RD_LATENCY = 1 the same strobes arrive at +2, +3, +4.
- Restart: i_start after 500 samples -> next write goes to address 0, o_count = 1.
- Clear mid-read: issue a read, then i_clear the next cycle -> no o_rd_valid; o_ram_rst pulses for 1 cycle; state IDLE.
- Circular (BRAM_LOG_CIRCULAR_EN): 1030 samples then i_stop -> o_wr_ptr = 6, o_count = 1024; read of address 5 returns sample 1029.
